alarm_sequencer: RTL and testbench

- Controls the LED alarm block in the digital clock.
- Holds the user alarm time and compares it against the running clock on each minute boundary.
- Issues the start pulse to the LED alarm and sequences ringing, snooze, dismiss and timeout.
- Sits between the timekeeping core and the LED alarm; all button inputs are debounced and synchronised upstream.

---
 rtl/alarm_pkg.sv | 22 ++
 rtl/posedge_detector.sv | 25 ++
 rtl/alarm_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_alarm_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer.
// Holds the FSM state encoding and the time-of-day limits used to validate alarm loads.
package alarm_pkg;

   localparam int unsigned HOUR_W   = 5;
   localparam int unsigned MIN_W    = 6;
   localparam int unsigned HOUR_MAX = 23;
   localparam int unsigned MIN_MAX  = 59;

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1,
      RINGING  = 2'd2,
      SNOOZED  = 2'd3
   } alarm_state_t;

   function automatic logic time_valid(input logic [HOUR_W-1:0] hour,
                                       input logic [MIN_W-1:0]  minute);
      return (hour <= HOUR_W'(HOUR_MAX)) && (minute <= MIN_W'(MIN_MAX));
   endfunction

endpackage

// File: rtl/posedge_detector.sv
// Registered rising-edge detector: one-cycle pulse the cycle after the input level rises.
// A held level produces a single pulse.
module posedge_detector (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic pulse_o
);

   logic prev_q;
   logic pulse_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         prev_q  <= sig_i;
         pulse_q <= sig_i & ~prev_q;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: stores the alarm time, matches it on minute ticks and drives the LED alarm
// through ringing, snooze, dismiss and timeout. All outputs are registered.
module alarm_sequencer
   import alarm_pkg::*;
#(
   parameter int unsigned RING_TIME    = 500_000_000,
   parameter int unsigned RING_WIDTH   = $clog2(RING_TIME),
   parameter int unsigned SNOOZE_MIN   = 5,
   parameter int unsigned SNOOZE_WIDTH = $clog2(SNOOZE_MIN + 1),
   parameter int unsigned MAX_SNOOZE   = 3,
   parameter int unsigned CNT_WIDTH    = $clog2(MAX_SNOOZE + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 min_tick,
   input  logic [HOUR_W-1:0]    cur_hour,
   input  logic [MIN_W-1:0]     cur_min,
   input  logic                 set_load,
   input  logic [HOUR_W-1:0]    set_hour,
   input  logic [MIN_W-1:0]     set_min,
   input  logic                 arm,
   input  logic                 snooze_btn,
   input  logic                 dismiss_btn,
   output logic                 alarm_start,
   output logic                 ringing,
   output logic                 snoozed,
   output logic [CNT_WIDTH-1:0] snooze_cnt,
   output logic                 missed,
   output logic                 set_err,
   output logic [HOUR_W-1:0]    alarm_hour,
   output logic [MIN_W-1:0]     alarm_min
);

   localparam logic [RING_WIDTH-1:0]   RingLast   = RING_WIDTH'(RING_TIME - 1);
   localparam logic [SNOOZE_WIDTH-1:0] SnoozeLast = SNOOZE_WIDTH'(SNOOZE_MIN);
   localparam logic [CNT_WIDTH-1:0]    CntMax     = CNT_WIDTH'(MAX_SNOOZE);

   alarm_state_t             state_q, state_d;
   logic [RING_WIDTH-1:0]    ring_cnt_q, ring_cnt_d;
   logic [SNOOZE_WIDTH-1:0]  snz_min_q, snz_min_d;
   logic [CNT_WIDTH-1:0]     snooze_cnt_q, snooze_cnt_d;
   logic                     missed_q, missed_d;
   logic [HOUR_W-1:0]        alarm_hour_q, alarm_hour_d;
   logic [MIN_W-1:0]         alarm_min_q, alarm_min_d;
   logic                     alarm_start_q, alarm_start_d;
   logic                     set_err_q, set_err_d;

   logic snooze_edge;
   logic dismiss_edge;
   logic load_ok;
   logic alarm_match;
   logic can_snooze;
   logic [SNOOZE_WIDTH-1:0] snz_min_inc;

   posedge_detector u_snooze_edge (
      .clk     (clk),
      .rst     (rst),
      .sig_i   (snooze_btn),
      .pulse_o (snooze_edge)
   );

   posedge_detector u_dismiss_edge (
      .clk     (clk),
      .rst     (rst),
      .sig_i   (dismiss_btn),
      .pulse_o (dismiss_edge)
   );

   // Match uses the stored time from before any same-cycle load.
   assign alarm_match = min_tick && (cur_hour == alarm_hour_q) && (cur_min == alarm_min_q);
   assign load_ok     = set_load && time_valid(set_hour, set_min);
   assign can_snooze  = snooze_cnt_q < CntMax;
   assign snz_min_inc = snz_min_q + 1'b1;

   always_comb begin
      state_d       = state_q;
      ring_cnt_d    = '0;
      snz_min_d     = snz_min_q;
      snooze_cnt_d  = snooze_cnt_q;
      missed_d      = missed_q;
      alarm_hour_d  = alarm_hour_q;
      alarm_min_d   = alarm_min_q;
      alarm_start_d = 1'b0;
      set_err_d     = 1'b0;

      if (set_load) begin
         if (load_ok) begin
            alarm_hour_d = set_hour;
            alarm_min_d  = set_min;
         end else begin
            set_err_d = 1'b1;
         end
      end

      if (!arm) begin
         state_d      = DISARMED;
         snz_min_d    = '0;
         snooze_cnt_d = '0;
      end else begin
         unique case (state_q)
            DISARMED: begin
               state_d  = ARMED;
               missed_d = 1'b0;
            end
            ARMED: begin
               if (dismiss_edge) begin
                  missed_d = 1'b0;
               end
               if (alarm_match) begin
                  state_d       = RINGING;
                  alarm_start_d = 1'b1;
               end
            end
            RINGING: begin
               ring_cnt_d = ring_cnt_q + 1'b1;
               if (dismiss_edge) begin
                  state_d      = ARMED;
                  snooze_cnt_d = '0;
                  missed_d     = 1'b0;
               end else if ((snooze_edge || (ring_cnt_q == RingLast)) && can_snooze) begin
                  state_d      = SNOOZED;
                  snooze_cnt_d = snooze_cnt_q + 1'b1;
                  snz_min_d    = '0;
               end else if (ring_cnt_q == RingLast) begin
                  state_d      = ARMED;
                  snooze_cnt_d = '0;
                  missed_d     = 1'b1;
               end
            end
            SNOOZED: begin
               if (dismiss_edge) begin
                  state_d      = ARMED;
                  snooze_cnt_d = '0;
                  missed_d     = 1'b0;
               end else if (min_tick) begin
                  snz_min_d = snz_min_inc;
                  if (snz_min_inc == SnoozeLast) begin
                     state_d       = RINGING;
                     alarm_start_d = 1'b1;
                     snz_min_d     = '0;
                  end
               end
            end
            default: state_d = DISARMED;
         endcase

         // A new alarm time cancels the event in progress.
         if (load_ok && ((state_q == RINGING) || (state_q == SNOOZED))) begin
            state_d       = ARMED;
            snooze_cnt_d  = '0;
            snz_min_d     = '0;
            alarm_start_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= DISARMED;
         ring_cnt_q    <= '0;
         snz_min_q     <= '0;
         snooze_cnt_q  <= '0;
         missed_q      <= 1'b0;
         alarm_hour_q  <= '0;
         alarm_min_q   <= '0;
         alarm_start_q <= 1'b0;
         set_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ring_cnt_q    <= ring_cnt_d;
         snz_min_q     <= snz_min_d;
         snooze_cnt_q  <= snooze_cnt_d;
         missed_q      <= missed_d;
         alarm_hour_q  <= alarm_hour_d;
         alarm_min_q   <= alarm_min_d;
         alarm_start_q <= alarm_start_d;
         set_err_q     <= set_err_d;
      end
   end

   assign alarm_start = alarm_start_q;
   assign ringing     = (state_q == RINGING);
   assign snoozed     = (state_q == SNOOZED);
   assign snooze_cnt  = snooze_cnt_q;
   assign missed      = missed_q;
   assign set_err     = set_err_q;
   assign alarm_hour  = alarm_hour_q;
   assign alarm_min   = alarm_min_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer: stimulus queues expected snapshots, a negedge monitor
// pops one whenever alarm_start, set_err or the bench probe strobe is high.
module tb_alarm_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       min_tick = 1'b0;
   logic [4:0] cur_hour = '0;
   logic [5:0] cur_min = '0;
   logic       set_load = 1'b0;
   logic [4:0] set_hour = '0;
   logic [5:0] set_min = '0;
   logic       arm = 1'b0;
   logic       snooze_btn = 1'b0;
   logic       dismiss_btn = 1'b0;
   logic       alarm_start;
   logic       ringing;
   logic       snoozed;
   logic [1:0] snooze_cnt;
   logic       missed;
   logic       set_err;
   logic [4:0] alarm_hour;
   logic [5:0] alarm_min;

   logic probe = 1'b0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      string      name;
      logic       start;
      logic       err;
      logic       ring;
      logic       snz;
      logic [1:0] cnt;
      logic       missed;
      logic [4:0] hr;
      logic [5:0] mn;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   exp_t fin_e;

   always #5 clk = ~clk;

   alarm_sequencer #(
      .RING_TIME  (20),
      .SNOOZE_MIN (2),
      .MAX_SNOOZE (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .min_tick    (min_tick),
      .cur_hour    (cur_hour),
      .cur_min     (cur_min),
      .set_load    (set_load),
      .set_hour    (set_hour),
      .set_min     (set_min),
      .arm         (arm),
      .snooze_btn  (snooze_btn),
      .dismiss_btn (dismiss_btn),
      .alarm_start (alarm_start),
      .ringing     (ringing),
      .snoozed     (snoozed),
      .snooze_cnt  (snooze_cnt),
      .missed      (missed),
      .set_err     (set_err),
      .alarm_hour  (alarm_hour),
      .alarm_min   (alarm_min)
   );

   always @(negedge clk) begin
      if (alarm_start || set_err || probe) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got start=%0b err=%0b ring=%0b snz=%0b cnt=%0d, required no output",
                     alarm_start, set_err, ringing, snoozed, snooze_cnt);
         end else begin
            mon_e = exp_q.pop_front();
            if ({alarm_start, set_err, ringing, snoozed, snooze_cnt, missed, alarm_hour, alarm_min} !==
                {mon_e.start, mon_e.err, mon_e.ring, mon_e.snz, mon_e.cnt, mon_e.missed, mon_e.hr,
                 mon_e.mn}) begin
               errors++;
               $display("FAIL %s: got start=%0b err=%0b ring=%0b snz=%0b cnt=%0d missed=%0b time=%0d:%0d, required start=%0b err=%0b ring=%0b snz=%0b cnt=%0d missed=%0b time=%0d:%0d",
                        mon_e.name, alarm_start, set_err, ringing, snoozed, snooze_cnt, missed,
                        alarm_hour, alarm_min, mon_e.start, mon_e.err, mon_e.ring, mon_e.snz,
                        mon_e.cnt, mon_e.missed, mon_e.hr, mon_e.mn);
            end
         end
      end
   end

   task automatic push(input string name, input logic start, input logic err, input logic ring,
                       input logic snz, input logic [1:0] cnt, input logic miss,
                       input logic [4:0] hr, input logic [5:0] mn);
      exp_t e;
      e.name = name; e.start = start; e.err = err; e.ring = ring; e.snz = snz;
      e.cnt = cnt; e.missed = miss; e.hr = hr; e.mn = mn;
      exp_q.push_back(e);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic snap(input string name, input logic ring, input logic snz, input logic [1:0] cnt,
                       input logic miss, input logic [4:0] hr, input logic [5:0] mn);
      push(name, 1'b0, 1'b0, ring, snz, cnt, miss, hr, mn);
      probe = 1'b1;
      tick();
      probe = 1'b0;
   endtask

   task automatic press_snooze;
      snooze_btn = 1'b1;
      tick();
      tick();
      snooze_btn = 1'b0;
   endtask

   task automatic press_dismiss;
      dismiss_btn = 1'b1;
      tick();
      tick();
      dismiss_btn = 1'b0;
   endtask

   task automatic minute(input logic [4:0] hr, input logic [5:0] mn);
      cur_hour = hr;
      cur_min  = mn;
      min_tick = 1'b1;
      tick();
      min_tick = 1'b0;
   endtask

   // Two snooze minutes; the second one re-rings.
   task automatic rering(input string name, input logic [1:0] cnt);
      minute(5'd9, 6'd0);
      tick();
      push(name, 1'b1, 1'b0, 1'b1, 1'b0, cnt, 1'b0, 5'd7, 6'd30);
      minute(5'd9, 6'd1);
   endtask

   task automatic load(input logic [4:0] hr, input logic [5:0] mn);
      set_hour = hr;
      set_min  = mn;
      set_load = 1'b1;
      tick();
      set_load = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, required finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) tick();
      snap("reset_state", 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 6'd0);
      rst = 1'b0;
      tick();

      // Load 07:30 while disarmed, then arm.
      load(5'd7, 6'd30);
      arm = 1'b1;
      tick();
      snap("armed", 1'b0, 1'b0, 2'd0, 1'b0, 5'd7, 6'd30);
      minute(5'd7, 6'd31);
      snap("no_match_0731", 1'b0, 1'b0, 2'd0, 1'b0, 5'd7, 6'd30);
      push("match_0730", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd7, 6'd30);
      minute(5'd7, 6'd30);

      // Manual snooze, re-ring after two minutes, dismiss.
      press_snooze();
      snap("snooze_edge", 1'b0, 1'b1, 2'd1, 1'b0, 5'd7, 6'd30);
      rering("snooze_rering", 2'd1);
      press_dismiss();
      snap("dismissed", 1'b0, 1'b0, 2'd0, 1'b0, 5'd7, 6'd30);
      tick();

      // Timeouts: two auto-snoozes, then a missed event.
      push("match_timeout", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd7, 6'd30);
      minute(5'd7, 6'd30);
      repeat (20) tick();
      snap("auto_snooze_1", 1'b0, 1'b1, 2'd1, 1'b0, 5'd7, 6'd30);
      rering("auto_rering_1", 2'd1);
      repeat (20) tick();
      snap("auto_snooze_2", 1'b0, 1'b1, 2'd2, 1'b0, 5'd7, 6'd30);
      rering("auto_rering_2", 2'd2);
      repeat (20) tick();
      snap("timeout_missed", 1'b0, 1'b0, 2'd0, 1'b1, 5'd7, 6'd30);
      arm = 1'b0;
      tick();
      snap("disarm_holds_missed", 1'b0, 1'b0, 2'd0, 1'b1, 5'd7, 6'd30);
      arm = 1'b1;
      tick();
      snap("rearm_clears_missed", 1'b0, 1'b0, 2'd0, 1'b0, 5'd7, 6'd30);

      // Snooze limit reached, then dismiss and snooze together.
      push("match_limit", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd7, 6'd30);
      minute(5'd7, 6'd30);
      press_snooze();
      rering("limit_rering_1", 2'd1);
      press_snooze();
      rering("limit_rering_2", 2'd2);
      press_snooze();
      snap("snooze_at_limit_ignored", 1'b1, 1'b0, 2'd2, 1'b0, 5'd7, 6'd30);
      snooze_btn  = 1'b1;
      dismiss_btn = 1'b1;
      tick();
      tick();
      snooze_btn  = 1'b0;
      dismiss_btn = 1'b0;
      snap("dismiss_beats_snooze", 1'b0, 1'b0, 2'd0, 1'b0, 5'd7, 6'd30);

      // Invalid loads keep the stored time.
      push("bad_hour_24", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 5'd7, 6'd30);
      load(5'd24, 6'd10);
      push("bad_min_60", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 5'd7, 6'd30);
      load(5'd7, 6'd60);
      tick();

      // Valid load while snoozed cancels the event.
      push("match_for_load", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd7, 6'd30);
      minute(5'd7, 6'd30);
      press_snooze();
      load(5'd6, 6'd15);
      snap("load_in_snooze", 1'b0, 1'b0, 2'd0, 1'b0, 5'd6, 6'd15);

      // Same-cycle load and tick: match against old time 06:15.
      set_hour = 5'd8;
      set_min  = 6'd0;
      set_load = 1'b1;
      push("match_old_time", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd8, 6'd0);
      minute(5'd6, 6'd15);
      set_load = 1'b0;

      // Asynchronous reset between edges while ringing.
      @(posedge clk);
      #3;
      rst = 1'b1;
      push("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 6'd0);
      probe = 1'b1;
      #4;
      rst = 1'b0;
      @(posedge clk);
      #1;
      probe = 1'b0;
      push("armed_after_reset", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 6'd0);
      minute(5'd0, 6'd0);
      repeat (3) tick();

      while (exp_q.size() > 0) begin
         fin_e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL %s: got no output, required start=%0b err=%0b ring=%0b snz=%0b cnt=%0d",
                  fin_e.name, fin_e.start, fin_e.err, fin_e.ring, fin_e.snz, fin_e.cnt);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
